majority_voter_filter: RTL and testbench

Parametrised N-input majority voter with configurable vote threshold and a registered persistence (debounce) filter on the vote.
- Samples an N-bit input vector on a valid strobe and reports the population count, raw vote, per-channel dissent and unanimity.
- Tracks a saturating count of non-unanimous samples.
- Used wherever redundant switch/sensor channels feed a single decision, for example board switch inputs driving LEDs or a downstream FSM.

---
 rtl/majority_pkg.sv | 25 ++
 rtl/majority_voter_filter_popcount.sv | 19 +
 rtl/majority_voter_filter.sv | 155 +++++++++++++++
 tb/tb_majority_voter_filter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/majority_pkg.sv
// Shared definitions for the majority voter: width helper, filter state
// encoding and default parameter values.
package majority_pkg;

    localparam int unsigned DEF_N_IN   = 3;
    localparam int unsigned DEF_THRESH = 2;
    localparam int unsigned DEF_HOLD   = 2;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } filt_state_t;

    // Bits needed to hold values 0..n-1; never less than 1.
    function automatic int unsigned clog2_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/majority_voter_filter_popcount.sv
// Purely combinational population count over an N_IN-bit vector.
module popcount_n
    import majority_pkg::*;
#(
    parameter  int unsigned N_IN = DEF_N_IN,
    localparam int unsigned CW   = clog2_w(N_IN + 1)
) (
    input  logic [N_IN-1:0] bits_i,
    output logic [CW-1:0]   count_o
);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/majority_voter_filter.sv
// N-input majority voter with a registered threshold vote, a persistence
// filter on the vote and a saturating count of non-unanimous samples.
module majority_voter_filter
    import majority_pkg::*;
#(
    parameter  int unsigned N_IN   = DEF_N_IN,
    parameter  int unsigned THRESH = DEF_THRESH,
    parameter  int unsigned HOLD   = DEF_HOLD,
    parameter  int unsigned CNT_W  = DEF_CNT_W,
    localparam int unsigned CW     = clog2_w(N_IN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [N_IN-1:0]   in_bits,
    input  logic              clear_cnt,
    output logic              out_valid,
    output logic [CW-1:0]     ones_count,
    output logic              raw_vote,
    output logic              vote,
    output logic              changed,
    output logic [N_IN-1:0]   dissent,
    output logic              unanimous,
    output logic [CNT_W-1:0]  disagree_cnt
);

    localparam int unsigned HW = clog2_w(HOLD);

    if (N_IN < 1 || THRESH < 1 || THRESH > N_IN || HOLD < 1) begin : g_param_err
        $error("majority_voter_filter: illegal parameters N_IN=%0d THRESH=%0d HOLD=%0d",
               N_IN, THRESH, HOLD);
    end

    logic [CW-1:0]    pop_cnt;
    logic             raw_d;
    logic             unan_d;
    logic [N_IN-1:0]  dissent_d;

    filt_state_t      state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             flip;
    logic             vote_q, vote_d;
    logic             changed_q, changed_d;

    logic             out_valid_q;
    logic [CW-1:0]    ones_q;
    logic             raw_q;
    logic [N_IN-1:0]  dissent_q;
    logic             unan_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [HW:0]      hold_inc;

    popcount_n #(.N_IN(N_IN)) u_pop (
        .bits_i  (in_bits),
        .count_o (pop_cnt)
    );

    assign raw_d     = (pop_cnt >= CW'(THRESH));
    assign unan_d    = (pop_cnt == '0) || (pop_cnt == CW'(N_IN));
    assign dissent_d = in_bits ^ {N_IN{raw_d}};
    assign hold_inc  = {1'b0, hold_q} + (HW+1)'(1);

    // Filter state register: frozen on idle cycles so gaps do not break a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STABLE;
            hold_q  <= '0;
            vote_q  <= 1'b0;
        end else if (in_valid) begin
            state_q <= state_d;
            hold_q  <= hold_d;
            vote_q  <= vote_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        flip    = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                if (raw_d != vote_q) begin
                    if (HOLD == 1) begin
                        flip = 1'b1;
                    end else begin
                        hold_d  = HW'(1);
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (raw_d == vote_q) begin
                    hold_d  = '0;
                    state_d = ST_STABLE;
                end else if (hold_inc == (HW+1)'(HOLD)) begin
                    flip    = 1'b1;
                    hold_d  = '0;
                    state_d = ST_STABLE;
                end else begin
                    hold_d  = hold_inc[HW-1:0];
                end
            end
            default: begin
                state_d = ST_STABLE;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        vote_d    = vote_q ^ flip;
        changed_d = in_valid & flip;
    end

    // Clear takes effect first so a same-cycle non-unanimous sample counts from zero.
    always_comb begin
        cnt_d = clear_cnt ? '0 : cnt_q;
        if (in_valid && !unan_d && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            changed_q   <= 1'b0;
            ones_q      <= '0;
            raw_q       <= 1'b0;
            dissent_q   <= '0;
            unan_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= in_valid;
            changed_q   <= changed_d;
            cnt_q       <= cnt_d;
            if (in_valid) begin
                ones_q    <= pop_cnt;
                raw_q     <= raw_d;
                dissent_q <= dissent_d;
                unan_q    <= unan_d;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign ones_count   = ones_q;
    assign raw_vote     = raw_q;
    assign vote         = vote_q;
    assign changed      = changed_q;
    assign dissent      = dissent_q;
    assign unanimous    = unan_q;
    assign disagree_cnt = cnt_q;

endmodule

// File: tb/tb_majority_voter_filter.sv
// Scoreboard bench for majority_voter_filter over three parameter sets.
module tb_majority_voter_filter;

    typedef struct packed {
        logic [2:0] oc;
        logic       raw;
        logic       vote;
        logic       chg;
        logic [4:0] dis;
        logic       unan;
        logic [7:0] dc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // DUT 0: defaults
    logic       r0, v0, c0;
    logic [2:0] b0;
    logic       ov0, raw0, vote0, chg0, un0;
    logic [1:0] oc0;
    logic [2:0] dis0;
    logic [7:0] dc0;
    // DUT 1: CNT_W=2
    logic       r1, v1, c1;
    logic [2:0] b1;
    logic       ov1, raw1, vote1, chg1, un1;
    logic [1:0] oc1;
    logic [2:0] dis1;
    logic [1:0] dc1;
    // DUT 2: N_IN=5, THRESH=4, HOLD=1
    logic       r2, v2, c2;
    logic [4:0] b2;
    logic       ov2, raw2, vote2, chg2, un2;
    logic [2:0] oc2;
    logic [4:0] dis2;
    logic [7:0] dc2;

    majority_voter_filter u0 (
        .clk(clk), .rst(r0), .in_valid(v0), .in_bits(b0), .clear_cnt(c0),
        .out_valid(ov0), .ones_count(oc0), .raw_vote(raw0), .vote(vote0),
        .changed(chg0), .dissent(dis0), .unanimous(un0), .disagree_cnt(dc0)
    );

    majority_voter_filter #(.CNT_W(2)) u1 (
        .clk(clk), .rst(r1), .in_valid(v1), .in_bits(b1), .clear_cnt(c1),
        .out_valid(ov1), .ones_count(oc1), .raw_vote(raw1), .vote(vote1),
        .changed(chg1), .dissent(dis1), .unanimous(un1), .disagree_cnt(dc1)
    );

    majority_voter_filter #(.N_IN(5), .THRESH(4), .HOLD(1)) u2 (
        .clk(clk), .rst(r2), .in_valid(v2), .in_bits(b2), .clear_cnt(c2),
        .out_valid(ov2), .ones_count(oc2), .raw_vote(raw2), .vote(vote2),
        .changed(chg2), .dissent(dis2), .unanimous(un2), .disagree_cnt(dc2)
    );

    function automatic exp_t mk(input logic [2:0] oc, input logic raw, input logic vote,
                                input logic chg, input logic [4:0] dis, input logic unan,
                                input logic [7:0] dc);
        exp_t e;
        e.oc = oc; e.raw = raw; e.vote = vote; e.chg = chg;
        e.dis = dis; e.unan = unan; e.dc = dc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [31:0] oc,
                       input logic [31:0] raw, input logic [31:0] vote, input logic [31:0] chg,
                       input logic [31:0] dis, input logic [31:0] unan, input logic [31:0] dc);
        chk({tag, ".ones_count"},   oc,   32'(e.oc));
        chk({tag, ".raw_vote"},     raw,  32'(e.raw));
        chk({tag, ".vote"},         vote, 32'(e.vote));
        chk({tag, ".changed"},      chg,  32'(e.chg));
        chk({tag, ".dissent"},      dis,  32'(e.dis));
        chk({tag, ".unanimous"},    unan, 32'(e.unan));
        chk({tag, ".disagree_cnt"}, dc,   32'(e.dc));
    endtask

    // Monitors: pop one expectation per out_valid; changed must be low otherwise.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (mon_en) begin
            if (ov0 === 1'b1) begin
                if (q0.size() == 0) chk("d0.unexpected_valid", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    cmp("d0", e, 32'(oc0), 32'(raw0), 32'(vote0), 32'(chg0), 32'(dis0), 32'(un0), 32'(dc0));
                end
            end else chk("d0.idle_changed", 32'(chg0), 32'd0);
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (mon_en) begin
            if (ov1 === 1'b1) begin
                if (q1.size() == 0) chk("d1.unexpected_valid", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    cmp("d1", e, 32'(oc1), 32'(raw1), 32'(vote1), 32'(chg1), 32'(dis1), 32'(un1), 32'(dc1));
                end
            end else chk("d1.idle_changed", 32'(chg1), 32'd0);
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (mon_en) begin
            if (ov2 === 1'b1) begin
                if (q2.size() == 0) chk("d2.unexpected_valid", 32'd1, 32'd0);
                else begin
                    e = q2.pop_front();
                    cmp("d2", e, 32'(oc2), 32'(raw2), 32'(vote2), 32'(chg2), 32'(dis2), 32'(un2), 32'(dc2));
                end
            end else chk("d2.idle_changed", 32'(chg2), 32'd0);
        end
    end

    task automatic idle_inputs();
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        c0 = 1'b0; c1 = 1'b0; c2 = 1'b0;
    endtask

    // Drives one sample for one cycle (called at a negedge, returns at the next).
    task automatic issue(input int d, input logic [4:0] bits, input logic clr, input exp_t e);
        case (d)
            0: begin v0 = 1'b1; b0 = bits[2:0]; c0 = clr; q0.push_back(e); end
            1: begin v1 = 1'b1; b1 = bits[2:0]; c1 = clr; q1.push_back(e); end
            default: begin v2 = 1'b1; b2 = bits; c2 = clr; q2.push_back(e); end
        endcase
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
        b0 = '0; b1 = '0; b2 = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset.out_valid",    32'(ov0),   32'd0);
        chk("reset.ones_count",   32'(oc0),   32'd0);
        chk("reset.raw_vote",     32'(raw0),  32'd0);
        chk("reset.vote",         32'(vote0), 32'd0);
        chk("reset.changed",      32'(chg0),  32'd0);
        chk("reset.dissent",      32'(dis0),  32'd0);
        chk("reset.unanimous",    32'(un0),   32'd0);
        chk("reset.disagree_cnt", 32'(dc0),   32'd0);
        chk("reset.d2_vote",      32'(vote2), 32'd0);
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
        mon_en = 1'b1;

        // First sample goes PENDING, second flips the vote
        issue(0, 5'b00011, 1'b0, mk(3'd2, 1, 0, 0, 5'b00100, 0, 8'd1));
        issue(0, 5'b00110, 1'b0, mk(3'd2, 1, 1, 1, 5'b00001, 0, 8'd2));
        @(negedge clk);
        chk("t2.vote_after_pulse", 32'(vote0), 32'd1);

        // Glitch rejection, then a genuine two-sample run
        issue(0, 5'b00000, 1'b0, mk(3'd0, 0, 1, 0, 5'b00000, 1, 8'd2));
        issue(0, 5'b00111, 1'b0, mk(3'd3, 1, 1, 0, 5'b00000, 1, 8'd2));
        issue(0, 5'b00000, 1'b0, mk(3'd0, 0, 1, 0, 5'b00000, 1, 8'd2));
        issue(0, 5'b00000, 1'b0, mk(3'd0, 0, 0, 1, 5'b00000, 1, 8'd2));

        // Rebuild vote=1, then reset in the middle of a PENDING run
        issue(0, 5'b00111, 1'b0, mk(3'd3, 1, 0, 0, 5'b00000, 1, 8'd2));
        issue(0, 5'b00111, 1'b0, mk(3'd3, 1, 1, 1, 5'b00000, 1, 8'd2));
        issue(0, 5'b00000, 1'b0, mk(3'd0, 0, 1, 0, 5'b00000, 1, 8'd2));
        r0 = 1'b1;
        v0 = 1'b1; b0 = 3'b011; c0 = 1'b1;
        @(negedge clk);
        idle_inputs();
        r0 = 1'b0;
        chk("t3.rst_out_valid", 32'(ov0),   32'd0);
        chk("t3.rst_vote",      32'(vote0), 32'd0);
        chk("t3.rst_cnt",       32'(dc0),   32'd0);
        issue(0, 5'b00000, 1'b0, mk(3'd0, 0, 0, 0, 5'b00000, 1, 8'd0));

        // Idle gap inside a run
        issue(0, 5'b00111, 1'b0, mk(3'd3, 1, 0, 0, 5'b00000, 1, 8'd0));
        repeat (5) begin
            @(negedge clk);
            chk("t4.gap_out_valid", 32'(ov0),   32'd0);
            chk("t4.gap_ones",      32'(oc0),   32'd3);
            chk("t4.gap_raw",       32'(raw0),  32'd1);
            chk("t4.gap_vote",      32'(vote0), 32'd0);
        end
        issue(0, 5'b00111, 1'b0, mk(3'd3, 1, 1, 1, 5'b00000, 1, 8'd0));

        // Saturating counter with CNT_W=2
        issue(1, 5'b00011, 1'b0, mk(3'd2, 1, 0, 0, 5'b00100, 0, 8'd1));
        issue(1, 5'b00101, 1'b0, mk(3'd2, 1, 1, 1, 5'b00010, 0, 8'd2));
        issue(1, 5'b00110, 1'b0, mk(3'd2, 1, 1, 0, 5'b00001, 0, 8'd3));
        issue(1, 5'b00001, 1'b0, mk(3'd1, 0, 1, 0, 5'b00001, 0, 8'd3));
        issue(1, 5'b00010, 1'b0, mk(3'd1, 0, 0, 1, 5'b00010, 0, 8'd3));
        issue(1, 5'b00101, 1'b1, mk(3'd2, 1, 0, 0, 5'b00010, 0, 8'd1));
        c1 = 1'b1;
        @(negedge clk);
        c1 = 1'b0;
        chk("t5.clear_only_cnt",   32'(dc1), 32'd0);
        chk("t5.clear_only_valid", 32'(ov1), 32'd0);

        // N_IN=5, THRESH=4, HOLD=1: immediate flips
        issue(2, 5'b01111, 1'b0, mk(3'd4, 1, 1, 1, 5'b10000, 0, 8'd1));
        issue(2, 5'b00111, 1'b0, mk(3'd3, 0, 0, 1, 5'b00111, 0, 8'd2));

        repeat (3) @(negedge clk);
        chk("end.pending_expectations", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
